// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA one bit per clock under a start/busy/done handshake.
// Define SEQ_SHIFTER_ROTATE_EN to build mode 11 as rotate-right; otherwise mode 11 passes num through.
module seq_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5    // must equal $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] num_i,
   input  logic [SHW-1:0]   shamt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam logic [1:0] M_SLL = 2'b00;
   localparam logic [1:0] M_SRL = 2'b01;
   localparam logic [1:0] M_SRA = 2'b10;
   localparam logic [1:0] M_ROR = 2'b11;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] step;
   logic             pass;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mode_q   <= M_SLL;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         result_q <= result_d;
      end
   end

   // Single-bit step on the working value, selected by the latched mode
   always_comb begin
      step = result_q;
      case (mode_q)
         M_SLL:   step = {result_q[WIDTH-2:0], 1'b0};
         M_SRL:   step = {1'b0, result_q[WIDTH-1:1]};
         M_SRA:   step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
         M_ROR:   step = {result_q[0], result_q[WIDTH-1:1]};
`endif
         default: step = result_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      result_d = result_q;
      pass     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               result_d = num_i;
               mode_d   = mode_i;
               cnt_d    = shamt_i;
               pass     = (shamt_i == '0);
`ifndef SEQ_SHIFTER_ROTATE_EN
               // Without rotate support, mode 11 completes immediately as a zero shift
               if (mode_i == M_ROR) begin
                  pass  = 1'b1;
                  cnt_d = '0;
               end
`endif
               state_d = pass ? DONE : SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            result_d = step;
            cnt_d    = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o   = (state_q == SHIFT);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter: latency, busy length and result per operation.
module tb_seq_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  mode;
   logic [31:0] num;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t_e0     = 0;
   int nbusy    = 0;

   seq_shifter #(.WIDTH(32), .SHW(5)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mode_i(mode),
      .num_i(num), .shamt_i(shamt), .busy_o(busy), .done_o(done), .result_o(result)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (busy) nbusy = nbusy + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      assert (act === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%h expected=%h", tag, act, exp);
      end
   endtask

   // Present a request for exactly one edge (E0)
   task automatic start_op(input logic [1:0] m, input logic [31:0] n, input logic [4:0] s);
      start = 1'b1; mode = m; num = n; shamt = s;
      nbusy = 0;
      t_e0  = cyc;
      tick();
      start = 1'b0; num = 32'h0; shamt = 5'd0; mode = 2'b00;
   endtask

   // Wait (bounded) for done, then check latency, busy cycles and result
   task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                            input logic [31:0] exp_res);
      int guard = 0;
      while (!done && guard < 100) begin
         tick();
         guard = guard + 1;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_lat"}, 32'(cyc - t_e0), 32'(exp_lat));
      check({tag, "_busy"}, 32'(nbusy), 32'(exp_busy));
      check({tag, "_res"}, result, exp_res);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 2'b00; num = 32'h0; shamt = 5'd0;
      tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", result, 32'h0);
      rst_n = 1'b1;
      tick();

      start_op(2'b10, 32'h8000_0010, 5'd4);
      wait_done("sra4", 5, 4, 32'hF800_0001);
      tick();
      check("sra4_done_drop", 32'(done), 32'd0);
      check("sra4_hold", result, 32'hF800_0001);

      start_op(2'b01, 32'h8000_0010, 5'd4);
      wait_done("srl4", 5, 4, 32'h0800_0001);
      tick();

      start_op(2'b00, 32'h0000_0001, 5'd31);
      wait_done("sll31", 32, 31, 32'h8000_0000);
      tick();

      start_op(2'b01, 32'hDEAD_BEEF, 5'd0);
      wait_done("zero", 1, 0, 32'hDEAD_BEEF);
      // shamt=0 request in the done cycle keeps done high for the new op
      start_op(2'b00, 32'h1234_5678, 5'd0);
      check("b2b0_done", 32'(done), 32'd1);
      check("b2b0_res", result, 32'h1234_5678);
      tick();
      check("b2b0_idle", 32'(done), 32'd0);

      start_op(2'b11, 32'h0000_00F1, 5'd4);
`ifdef SEQ_SHIFTER_ROTATE_EN
      wait_done("ror4", 5, 4, 32'h1000_000F);
`else
      wait_done("ror4", 1, 0, 32'h0000_00F1);
`endif
      tick();

      // Start while busy is ignored
      start_op(2'b01, 32'hF000_0000, 5'd8);
      tick(); tick();
      start = 1'b1; mode = 2'b00; num = 32'h0; shamt = 5'd1;
      tick();
      start = 1'b0;
      check("ign_busy", 32'(busy), 32'd1);
      wait_done("ign", 9, 8, 32'h00F0_0000);
      start_op(2'b00, 32'h0000_0001, 5'd2);
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_done", 32'(done), 32'd0);
      wait_done("b2b", 3, 2, 32'h0000_0004);
      tick();

      // Reset mid-operation
      start_op(2'b00, 32'h0000_0001, 5'd10);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_res", result, 32'h0);
      tick();
      check("mid_idle", 32'(busy | done), 32'd0);
      start_op(2'b01, 32'h0000_0100, 5'd8);
      wait_done("post", 9, 8, 32'h0000_0001);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle barrel-replacement shift unit for the datapath ALU, supporting logical left, logical right and arithmetic right shifts of a WIDTH-bit operand by a variable amount. It moves the operand one bit position per clock under a start/busy/done handshake, trading latency for area relative to a combinational shifter. The ALU control FSM issues `start` and stalls on `busy` until `done`. An optional rotate-right mode is compiled in by macro.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- SHW, 5, shift-amount width; must equal clog2(WIDTH)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when not busy
- mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration)
- num  in  WIDTH  operand, captured with start
- shamt  in  SHW  shift amount, captured with start (0..WIDTH-1)
- busy  out  1  high while shifting; start ignored
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  working/final value; holds after done until next accepted start

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE or DONE, start=1: load result←num, cnt←shamt, latch mode. shamt=0 → DONE; else → SHIFT.
- IDLE or DONE, start=0: DONE → IDLE; IDLE stays.
- SHIFT: each cycle apply one 1-bit step to result, cnt←cnt−1; when cnt was 1 → DONE.
- Step rules: SLL result←{result[W-2:0],0}; SRL ←{0,result[W-1:1]}; SRA ←{result[W-1],result[W-1:1]} (sign bit replicated); ROR ←{result[0],result[W-1:1]}.
- busy = (state==SHIFT); done = (state==DONE). Both registered-state decodes, glitch-free.
- start while busy: ignored, no queuing; num/shamt/mode changes while busy have no effect.
- Back-to-back: start asserted during the done cycle is accepted; done drops next cycle unless new shamt=0 (then done stays high one more cycle for the new op).
- Reset mid-operation: rst_n=0 at any edge aborts; outputs take reset values.
- Reset values: busy=0, done=0, result=0, internal cnt=0, mode=00.

## Timing
- Edge E0 = edge at which start is accepted.
- shamt=n: SHIFT occupies edges E1..En; done high in the cycle after En... precisely: done high in cycle following edge E(n) for n≥1 with state DONE entered at En; for n=0 DONE entered at E0.
- Latency start→done: n+1 cycles (n=0 → 1 cycle, n=31 → 32 cycles).
- busy high for exactly n cycles, immediately after E0.
- result updates every SHIFT edge; consumers sample only on done.

## Configuration
- Macro SEQ_SHIFTER_ROTATE_EN.
- Defined: mode 11 performs rotate-right per step rule above, latency n+1.
- Undefined: mode 11 is pass-through: treated as shamt=0 regardless of shamt; result=num, done one cycle after E0, busy never asserted. No rotate logic synthesised.

## Test plan
- SRA: num=32'h8000_0010, shamt=4, mode=10 → busy 4 cycles, done on 5th cycle, result=32'hF800_0001; SRL same inputs → 32'h0800_0001.
- SLL: num=32'h0000_0001, shamt=31 → busy 31 cycles, done 32 cycles after start, result=32'h8000_0000.
- shamt=0, num=32'hDEAD_BEEF, any mode → busy never high, done 1 cycle after start, result=32'hDEAD_BEEF.
- ROR with macro: num=32'h0000_00F1, shamt=4 → result=32'h1000_000F after 5 cycles; without macro → result=32'h0000_00F1, done after 1 cycle.
- Start while busy: op1 SRL num=32'hF000_0000 shamt=8, pulse start with num=0 shamt=1 at cycle 3 → ignored, result=32'h00F0_0000; then start in done cycle with SLL num=1 shamt=2 → accepted, result=32'h0000_0004.
- Reset mid-op: rst_n=0 at cycle 3 of a shamt=10 op → next cycle busy=0, done=0, result=0, state IDLE; fresh start afterwards completes normally.
